// File: rtl/i2c_target_if.sv
// Bus bundle between the I2C target and its surroundings: pin-level SCL/SDA,
// the register port and status strobes, plus the FSM state for observation.
interface i2c_target_if;
    logic       scl;
    logic       sda_sense;
    logic       sda_drive;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       busy;
    logic       updated;
    logic [3:0] state_dbg;

    modport slave (
        input  scl, sda_sense, reg_rdata,
        output sda_drive, reg_addr, reg_wdata, reg_we, busy, updated, state_dbg
    );

    modport master (
        output scl, sda_sense, reg_rdata,
        input  sda_drive, reg_addr, reg_wdata, reg_we, busy, updated, state_dbg
    );
endinterface

// File: rtl/i2c_target.sv
// I2C target with a pointer-based 8-bit register port, oversampled in clk.
// Optional bus timeout enabled by defining I2C_TARGET_TIMEOUT_EN.
module i2c_target #(
    parameter logic [6:0]  dev_addr = 7'h42,
    parameter int unsigned filt     = 3,
    parameter int unsigned to_w     = 16
) (
    input  logic          clk,
    input  logic          rst,
    i2c_target_if.slave   bus
);
    if (filt < 1 || filt > 15 || to_w < 1) begin : g_bad_param
        $error("i2c_target: filt must be 1..15 and to_w at least 1");
    end

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, WPTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, MACK
    } state_t;

    localparam logic [3:0] FILT_M1 = 4'(filt - 1);

    // Index 0 carries SCL, index 1 carries SDA through sync, filter and edge history.
    logic [1:0] s1_q, s2_q, flt_q, prv_q;
    logic [3:0] fcnt_q [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q  <= 2'b11;
            s2_q  <= 2'b11;
            flt_q <= 2'b11;
            prv_q <= 2'b11;
            for (int i = 0; i < 2; i++) fcnt_q[i] <= '0;
        end else begin
            s1_q  <= {bus.sda_sense, bus.scl};
            s2_q  <= s1_q;
            prv_q <= flt_q;
            for (int i = 0; i < 2; i++) begin
                if (s2_q[i] != flt_q[i]) begin
                    if (fcnt_q[i] == FILT_M1) begin
                        flt_q[i]  <= s2_q[i];
                        fcnt_q[i] <= '0;
                    end else begin
                        fcnt_q[i] <= fcnt_q[i] + 4'd1;
                    end
                end else begin
                    fcnt_q[i] <= '0;
                end
            end
        end
    end

    logic scl_f, sda_f, scl_rise, scl_fall, start_ev, stop_ev;
    assign scl_f    = flt_q[0];
    assign sda_f    = flt_q[1];
    assign scl_rise = flt_q[0] & ~prv_q[0];
    assign scl_fall = ~flt_q[0] & prv_q[0];
    assign start_ev = prv_q[1] & ~flt_q[1] & flt_q[0] & prv_q[0];
    assign stop_ev  = ~prv_q[1] & flt_q[1] & flt_q[0] & prv_q[0];

    state_t     state_q;
    logic [7:0] shreg_q, reg_addr_q, reg_wdata_q, byte_d;
    logic [3:0] bit_cnt_q;
    logic       sda_q, reg_we_q, busy_q, updated_q, ack_on_q, rw_q, wrote_q;
    logic       to_hit;

    assign byte_d = {shreg_q[6:0], sda_f};

`ifdef I2C_TARGET_TIMEOUT_EN
    logic [to_w-1:0] to_q;
    always_ff @(posedge clk) begin
        if (rst || scl_rise || scl_fall || !busy_q || scl_f || to_hit) to_q <= '0;
        else                                                          to_q <= to_q + 1'b1;
    end
    assign to_hit = busy_q & ~scl_f & (&to_q);
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shreg_q     <= '0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            bit_cnt_q   <= '0;
            sda_q       <= 1'b1;
            reg_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            updated_q   <= 1'b0;
            ack_on_q    <= 1'b0;
            rw_q        <= 1'b0;
            wrote_q     <= 1'b0;
        end else begin
            reg_we_q  <= 1'b0;
            updated_q <= 1'b0;
            if (start_ev) begin
                state_q   <= ADDR;
                bit_cnt_q <= '0;
                sda_q     <= 1'b1;
                busy_q    <= 1'b0;
                wrote_q   <= 1'b0;
                ack_on_q  <= 1'b0;
            end else if (stop_ev) begin
                state_q   <= IDLE;
                sda_q     <= 1'b1;
                busy_q    <= 1'b0;
                updated_q <= wrote_q;
                wrote_q   <= 1'b0;
                ack_on_q  <= 1'b0;
            end else if (to_hit) begin
                state_q  <= IDLE;
                sda_q    <= 1'b1;
                busy_q   <= 1'b0;
                wrote_q  <= 1'b0;
                ack_on_q <= 1'b0;
            end else begin
                case (state_q)
                    ADDR, WPTR, WDATA: if (scl_rise) begin
                        shreg_q <= byte_d;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_q <= '0;
                            ack_on_q  <= 1'b0;
                            if (state_q == ADDR) begin
                                if (byte_d[7:1] == dev_addr) begin
                                    rw_q    <= byte_d[0];
                                    state_q <= ADDR_ACK;
                                end else begin
                                    state_q <= IDLE;
                                end
                            end else if (state_q == WPTR) begin
                                reg_addr_q <= byte_d;
                                state_q    <= PTR_ACK;
                            end else begin
                                reg_wdata_q <= byte_d;
                                reg_we_q    <= 1'b1;
                                wrote_q     <= 1'b1;
                                state_q     <= WDATA_ACK;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                    ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
                        if (!ack_on_q) begin
                            sda_q    <= 1'b0;
                            ack_on_q <= 1'b1;
                            if (state_q == ADDR_ACK) busy_q <= 1'b1;
                        end else begin
                            ack_on_q <= 1'b0;
                            sda_q    <= 1'b1;
                            if (state_q == ADDR_ACK && rw_q) begin
                                // First read bit goes out on the same edge that ends the ACK.
                                shreg_q   <= {reg_rdata_s(), 1'b1};
                                sda_q     <= bus.reg_rdata[7];
                                bit_cnt_q <= 4'd1;
                                state_q   <= RDATA;
                            end else if (state_q == ADDR_ACK) begin
                                state_q <= WPTR;
                            end else if (state_q == PTR_ACK) begin
                                state_q <= WDATA;
                            end else begin
                                reg_addr_q <= reg_addr_q + 8'd1;
                                state_q    <= WDATA;
                            end
                        end
                    end
                    RDATA: if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_q     <= 1'b1;
                            bit_cnt_q <= '0;
                            ack_on_q  <= 1'b0;
                            state_q   <= MACK;
                        end else begin
                            sda_q     <= shreg_q[7];
                            shreg_q   <= {shreg_q[6:0], 1'b1};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                    MACK: begin
                        if (scl_rise) begin
                            if (!sda_f) begin
                                reg_addr_q <= reg_addr_q + 8'd1;
                                ack_on_q   <= 1'b1;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else if (scl_fall && ack_on_q) begin
                            shreg_q   <= {reg_rdata_s(), 1'b1};
                            sda_q     <= bus.reg_rdata[7];
                            bit_cnt_q <= 4'd1;
                            ack_on_q  <= 1'b0;
                            state_q   <= RDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    function automatic logic [6:0] reg_rdata_s();
        return bus.reg_rdata[6:0];
    endfunction

    assign bus.sda_drive = sda_q;
    assign bus.reg_addr  = reg_addr_q;
    assign bus.reg_wdata = reg_wdata_q;
    assign bus.reg_we    = reg_we_q;
    assign bus.busy      = busy_q;
    assign bus.updated   = updated_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bit-banged I2C master, register model and write scoreboard.
module tb_i2c_target;
    localparam int Q = 20;
    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_WPTR = 4'd3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   upd_cnt = 0;
    logic sda_low_seen = 1'b0;
    logic ack;
    logic [7:0] rd;
    logic [15:0] exp_q[$];

    i2c_target_if bus ();

    i2c_target #(.dev_addr(7'h42), .filt(3), .to_w(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.scl       = scl_m;
    assign bus.sda_sense = sda_m & bus.sda_drive;
    always @(posedge clk) bus.reg_rdata <= bus.reg_addr ^ 8'hFF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard and status monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.updated) upd_cnt++;
            if (!bus.sda_drive) sda_low_seen = 1'b1;
            if (bus.reg_we) begin
                if (exp_q.size() == 0) check("unexpected_we", {bus.reg_addr, bus.reg_wdata}, 32'hDEAD);
                else check("write", {bus.reg_addr, bus.reg_wdata}, exp_q.pop_front());
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        sda_m = 1'b0; wait_clks(Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        sda_m = 1'b1; wait_clks(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic a);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; wait_clks(Q);
            scl_m = 1'b1; wait_clks(2 * Q);
            scl_m = 1'b0; wait_clks(Q);
        end
        sda_m = 1'b1; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        a = bus.sda_sense; wait_clks(Q);
        scl_m = 1'b0; wait_clks(Q);
    endtask

    task automatic read_byte(input logic m_ack, output logic [7:0] d);
        sda_m = 1'b1;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            wait_clks(Q);
            scl_m = 1'b1; wait_clks(Q);
            d = {d[6:0], bus.sda_sense}; wait_clks(Q);
            scl_m = 1'b0;
        end
        wait_clks(Q);
        sda_m = ~m_ack; wait_clks(Q);
        scl_m = 1'b1; wait_clks(2 * Q);
        scl_m = 1'b0; wait_clks(Q);
        sda_m = 1'b1;
    endtask

    initial begin
        wait_clks(6);
        rst = 1'b0;
        wait_clks(2);
        check("rst_sda_drive", bus.sda_drive, 1);
        check("rst_reg_addr", bus.reg_addr, 0);
        check("rst_reg_wdata", bus.reg_wdata, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_state", bus.state_dbg, S_IDLE);
        wait_clks(Q);

        // Write pointer 0x10 then two data bytes.
        upd_cnt = 0;
        i2c_start();
        write_byte(8'h84, ack); check("w_addr_ack", ack, 0);
        check("w_busy", bus.busy, 1);
        write_byte(8'h10, ack); check("w_ptr_ack", ack, 0);
        exp_q.push_back(16'h10A5);
        write_byte(8'hA5, ack); check("w_d0_ack", ack, 0);
        exp_q.push_back(16'h115A);
        write_byte(8'h5A, ack); check("w_d1_ack", ack, 0);
        i2c_stop(); wait_clks(Q);
        check("w_updated", upd_cnt, 1);
        check("w_busy_end", bus.busy, 0);
        check("w_q_empty", exp_q.size(), 0);

        // Pointer write, repeated START, two-byte read.
        upd_cnt = 0;
        i2c_start();
        write_byte(8'h84, ack); check("r_addr_ack", ack, 0);
        write_byte(8'h20, ack); check("r_ptr_ack", ack, 0);
        i2c_start();
        write_byte(8'h85, ack); check("r_raddr_ack", ack, 0);
        read_byte(1'b1, rd); check("r_data0", rd, 8'hDF);
        read_byte(1'b0, rd); check("r_data1", rd, 8'hDE);
        i2c_stop(); wait_clks(Q);
        check("r_no_updated", upd_cnt, 0);
        check("r_busy_end", bus.busy, 0);

        // Foreign address is ignored until the next START.
        sda_low_seen = 1'b0;
        i2c_start();
        write_byte(8'h86, ack); check("x_nack", ack, 1);
        check("x_busy", bus.busy, 0);
        write_byte(8'h84, ack); check("x_ignored", ack, 1);
        check("x_sda_never_low", sda_low_seen, 0);
        i2c_stop(); wait_clks(Q);

        // Pointer wrap from 0xFF to 0x00.
        i2c_start();
        write_byte(8'h84, ack); check("wr_addr_ack", ack, 0);
        write_byte(8'hFF, ack); check("wr_ptr_ack", ack, 0);
        exp_q.push_back(16'hFF11);
        write_byte(8'h11, ack); check("wr_d0_ack", ack, 0);
        exp_q.push_back(16'h0022);
        write_byte(8'h22, ack); check("wr_d1_ack", ack, 0);
        i2c_stop(); wait_clks(Q);
        check("wr_q_empty", exp_q.size(), 0);

        // Single-clock SDA glitches must not look like START or STOP.
        sda_m = 1'b0; wait_clks(1); sda_m = 1'b1; wait_clks(Q);
        check("g_idle_state", bus.state_dbg, S_IDLE);
        check("g_idle_busy", bus.busy, 0);
        i2c_start();
        write_byte(8'h84, ack); check("g_addr_ack", ack, 0);
        sda_m = 1'b0; wait_clks(Q);
        scl_m = 1'b1; wait_clks(Q);
        sda_m = 1'b1; wait_clks(1); sda_m = 1'b0; wait_clks(Q);
        check("g_busy_state", bus.state_dbg, S_WPTR);
        check("g_busy", bus.busy, 1);
        sda_m = 1'b1; wait_clks(Q);
        check("g_stop_state", bus.state_dbg, S_IDLE);

`ifdef I2C_TARGET_TIMEOUT_EN
        upd_cnt = 0;
        i2c_start();
        write_byte(8'h84, ack); check("t_addr_ack", ack, 0);
        wait_clks(300);
        check("t_busy", bus.busy, 0);
        check("t_sda_drive", bus.sda_drive, 1);
        check("t_state", bus.state_dbg, S_IDLE);
        i2c_start();
        write_byte(8'h84, ack); check("t_again_ack", ack, 0);
        write_byte(8'h30, ack); check("t_ptr_ack", ack, 0);
        i2c_stop(); wait_clks(Q);
        check("t_no_updated", upd_cnt, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
